// File: rtl/jk_bank_sequencer.sv
// rtl/jk_bank_sequencer.sv - command sequencer driving per-bit J/K of a JK register bank
// Drives one bank step per clock edge in EXEC; count/shift steps use live Q feedback.
module jk_bank_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [2:0] OP_NOP    = 3'b000;
   localparam logic [2:0] OP_CLEAR  = 3'b001;
   localparam logic [2:0] OP_SET    = 3'b010;
   localparam logic [2:0] OP_LOAD   = 3'b011;
   localparam logic [2:0] OP_TOGGLE = 3'b100;
   localparam logic [2:0] OP_CNT_UP = 3'b101;
   localparam logic [2:0] OP_CNT_DN = 3'b110;
   localparam logic [2:0] OP_SHIFT  = 3'b111;

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] accept_rem;
   logic [WIDTH-1:0] up_mask, dn_mask, shift_next;

   // Bits that flip on +1 / -1 are exactly the JK toggle masks for counting.
   assign up_mask    = q ^ (q + {{(WIDTH-1){1'b0}}, 1'b1});
   assign dn_mask    = q ^ (q - {{(WIDTH-1){1'b0}}, 1'b1});
   assign shift_next = {q[WIDTH-2:0], data_q[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NOP;
         data_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      case (cmd_op)
         OP_NOP:                       accept_rem = '0;
         OP_CNT_UP, OP_CNT_DN, OP_SHIFT: accept_rem = cmd_count;
         default:                      accept_rem = {{(CNT_W-1){1'b0}}, 1'b1};
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      data_d    = data_q;
      rem_d     = rem_q;
      j         = '0;
      k         = '0;
      cmd_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               op_d    = cmd_op;
               data_d  = cmd_data;
               rem_d   = accept_rem;
               state_d = (accept_rem == '0) ? ST_DONE : ST_EXEC;
            end
         end
         ST_EXEC: begin
            busy = 1'b1;
            case (op_q)
               OP_CLEAR:  begin j = '0;          k = '1;           end
               OP_SET:    begin j = '1;          k = '0;           end
               OP_LOAD:   begin j = data_q;      k = ~data_q;      end
               OP_TOGGLE: begin j = data_q;      k = data_q;       end
               OP_CNT_UP: begin j = up_mask;     k = up_mask;      end
               OP_CNT_DN: begin j = dn_mask;     k = dn_mask;      end
               OP_SHIFT:  begin j = shift_next;  k = ~shift_next;  end
               default:   begin j = '0;          k = '0;           end
            endcase
            rem_d = rem_q - {{(CNT_W-1){1'b0}}, 1'b1};
            if (rem_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb/tb_jk_bank_sequencer.sv - self-checking bench for jk_bank_sequencer with a behavioural JK bank
module tb_jk_bank_sequencer;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_data;
   logic [7:0] cmd_count;
   logic [7:0] bank;
   logic [7:0] j;
   logic [7:0] k;
   logic       busy;
   logic       done;
   logic       preload;
   logic [7:0] preload_val;

   int errors = 0;
   int checks = 0;

   jk_bank_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_count (cmd_count),
      .q         (bank),
      .j         (j),
      .k         (k),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural JK cells with no reset; preload seeds a starting value.
   always @(posedge clk) begin
      if (preload) begin
         bank <= preload_val;
      end else begin
         for (int i = 0; i < 8; i++) begin
            case ({j[i], k[i]})
               2'b10:   bank[i] <= 1'b1;
               2'b01:   bank[i] <= 1'b0;
               2'b11:   bank[i] <= ~bank[i];
               default: bank[i] <= bank[i];
            endcase
         end
      end
   end

   typedef struct {
      logic [2:0] op;
      logic [7:0] start;
      logic [7:0] data;
      logic [7:0] count;
      logic [7:0] final_q;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_step(input logic [2:0] op, input logic [7:0] qv,
                                             input logic [7:0] d);
      case (op)
         3'd1:    return 8'h00;
         3'd2:    return 8'hFF;
         3'd3:    return d;
         3'd4:    return qv ^ d;
         3'd5:    return qv + 8'd1;
         3'd6:    return qv - 8'd1;
         3'd7:    return {qv[6:0], d[0]};
         default: return qv;
      endcase
   endfunction

   function automatic int model_steps(input logic [2:0] op, input logic [7:0] cnt);
      if (op == 3'd0) return 0;
      if (op >= 3'd5) return int'(cnt);
      return 1;
   endfunction

   task automatic do_preload(input logic [7:0] v);
      @(negedge clk);
      preload = 1'b1;
      preload_val = v;
      @(negedge clk);
      preload = 1'b0;
   endtask

   task automatic do_cmd(input logic [2:0] op, input logic [7:0] d, input logic [7:0] cnt,
                         input logic [7:0] start, input logic noise, output logic [7:0] fin);
      logic [7:0] cur;
      int n;
      n = model_steps(op, cnt);
      cur = start;
      @(negedge clk);
      chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      cmd_count = cnt;
      @(posedge clk);
      for (int c = 0; c <= n; c++) begin
         @(negedge clk);
         if (c > 0) cur = model_step(op, cur, d);
         chk("q_after_edge", 32'(bank), 32'(cur));
         chk("done_pulse", 32'(done), 32'(c == n));
         chk("busy_active", 32'(busy), 32'd1);
         chk("ready_low_busy", 32'(cmd_ready), 32'd0);
         cmd_op    = 3'($urandom);
         cmd_data  = 8'($urandom);
         cmd_count = 8'($urandom);
         cmd_valid = noise & 1'($urandom_range(0, 1));
         @(posedge clk);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("ready_after", 32'(cmd_ready), 32'd1);
      chk("busy_after", 32'(busy), 32'd0);
      chk("done_after", 32'(done), 32'd0);
      chk("q_idle", 32'(bank), 32'(cur));
      fin = cur;
   endtask

   initial begin
      logic [7:0] fin;
      logic [7:0] mq;

      tbl[0]  = '{3'd3, 8'h00, 8'hA5, 8'h07, 8'hA5};
      tbl[1]  = '{3'd5, 8'hFE, 8'h00, 8'h03, 8'h01};
      tbl[2]  = '{3'd6, 8'h01, 8'h00, 8'h02, 8'hFF};
      tbl[3]  = '{3'd4, 8'hFF, 8'h0F, 8'h09, 8'hF0};
      tbl[4]  = '{3'd7, 8'h81, 8'h01, 8'h04, 8'h1F};
      tbl[5]  = '{3'd7, 8'h5A, 8'h01, 8'h00, 8'h5A};
      tbl[6]  = '{3'd1, 8'h77, 8'h33, 8'h05, 8'h00};
      tbl[7]  = '{3'd2, 8'h12, 8'h00, 8'h00, 8'hFF};
      tbl[8]  = '{3'd0, 8'h3C, 8'hFF, 8'h09, 8'h3C};
      tbl[9]  = '{3'd5, 8'h10, 8'h00, 8'h00, 8'h10};
      tbl[10] = '{3'd6, 8'h01, 8'h00, 8'h03, 8'hFE};
      tbl[11] = '{3'd7, 8'hC3, 8'h00, 8'h02, 8'h0C};
      tbl[12] = '{3'd5, 8'h00, 8'h00, 8'hFF, 8'hFF};
      tbl[13] = '{3'd4, 8'h5A, 8'h00, 8'h03, 8'h5A};

      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_op = 3'd0;
      cmd_data = 8'h00;
      cmd_count = 8'h00;
      preload = 1'b1;
      preload_val = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      preload = 1'b0;
      cmd_valid = 1'b1;
      cmd_op = 3'd2;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rst_j", 32'(j), 32'd0);
         chk("rst_k", 32'(k), 32'd0);
         chk("rst_ready", 32'(cmd_ready), 32'd1);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
         chk("rst_q_held", 32'(bank), 32'h3C);
      end
      cmd_valid = 1'b0;
      rst_n = 1'b1;

      for (int t = 0; t < 14; t++) begin
         do_preload(tbl[t].start);
         do_cmd(tbl[t].op, tbl[t].data, tbl[t].count, tbl[t].start, 1'b1, fin);
         chk("tbl_final_q", 32'(bank), 32'(tbl[t].final_q));
      end

      // Reset lands just after E2 of a 5-step count-up from 0x00.
      do_preload(8'h00);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op = 3'd5;
      cmd_count = 8'd5;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_j", 32'(j), 32'd0);
      chk("abort_k", 32'(k), 32'd0);
      chk("abort_ready", 32'(cmd_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_q", 32'(bank), 32'h02);
      @(negedge clk);
      @(negedge clk);
      chk("abort_q_hold", 32'(bank), 32'h02);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready_rel", 32'(cmd_ready), 32'd1);
      chk("abort_done_rel", 32'(done), 32'd0);
      do_cmd(3'd1, 8'hFF, 8'h09, 8'h02, 1'b0, fin);
      chk("abort_clear", 32'(bank), 32'h00);

      mq = 8'($urandom);
      do_preload(mq);
      for (int r = 0; r < 40; r++) begin
         do_cmd(3'($urandom), 8'($urandom), 8'($urandom_range(0, 6)), mq, 1'b1, mq);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
